// File: rtl/dcache_mem_responder.sv
// Memory-side burst responder: turns cache-line read requests into sequential SRAM reads and forwards word writes.
// Define DCACHE_MEMRESP_WRAP_EN for critical-word-first bursts that wrap inside the aligned 32-word line.
module dcache_mem_responder #(
    parameter int BURSTLEN = 8,
    parameter int RDLAT    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_rdreq,
    input  logic        mem_wrreq,
    input  logic [31:0] mem_wrdata,
    output logic [31:0] mem_out,
    output logic        mem_valid,
    output logic [15:0] mem_burstlen,
    output logic        req_overrun,
    output logic [29:0] sram_addr,
    output logic        sram_re,
    output logic        sram_we,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [5:0] LAST_CNT = 6'(BURSTLEN - 1);

    logic [1:0]       state_q, state_d;
    logic [29:0]      base_q, base_d;
    logic [5:0]       issue_cnt_q, issue_cnt_d;
    logic [5:0]       beat_cnt_q, beat_cnt_d;
    logic [RDLAT-1:0] pipe_q, pipe_d;
    logic             overrun_q, overrun_d;
    logic [29:0]      sram_addr_q, sram_addr_d;
    logic             sram_re_q, sram_re_d;
    logic             sram_we_q, sram_we_d;
    logic [31:0]      sram_wdata_q, sram_wdata_d;
    logic [31:0]      mem_out_q, mem_out_d;
    logic             mem_valid_q, mem_valid_d;

    logic [29:0]      burst_addr;
    logic             beat;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[1:0];

`ifdef DCACHE_MEMRESP_WRAP_EN
    assign burst_addr = {base_q[29:5], base_q[4:0] + issue_cnt_q[4:0]};
`else
    assign burst_addr = base_q + {24'd0, issue_cnt_q};
`endif

    // The pipe tracks sram_re as registered on the output, so its tail marks the cycle sram_rdata is valid.
    generate
        if (RDLAT == 1) begin : g_pipe_single
            assign pipe_d = sram_re_q;
        end else begin : g_pipe_multi
            assign pipe_d = {pipe_q[RDLAT-2:0], sram_re_q};
        end
    endgenerate

    assign beat = pipe_q[RDLAT-1];

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        beat_cnt_d   = beat ? beat_cnt_q + 6'd1 : beat_cnt_q;
        overrun_d    = overrun_q;
        sram_addr_d  = sram_addr_q;
        sram_re_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_wdata_d = sram_wdata_q;
        mem_valid_d  = beat;
        mem_out_d    = beat ? sram_rdata : mem_out_q;

        if (mem_wrreq) begin
            sram_we_d    = 1'b1;
            sram_addr_d  = mem_addr[31:2];
            sram_wdata_d = mem_wrdata;
        end

        // A write in the same cycle pre-empts the read issue; issue_cnt simply holds.
        case (state_q)
            IDLE: begin
                if (mem_rdreq) begin
                    base_d      = mem_addr[31:2];
                    issue_cnt_d = 6'd0;
                    beat_cnt_d  = 6'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_wrreq) begin
                    sram_re_d   = 1'b1;
                    sram_addr_d = burst_addr;
                    issue_cnt_d = issue_cnt_q + 6'd1;
                    if (issue_cnt_q == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat && (beat_cnt_q == LAST_CNT)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mem_rdreq && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            beat_cnt_q   <= '0;
            pipe_q       <= '0;
            overrun_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_re_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= '0;
            mem_out_q    <= '0;
            mem_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            pipe_q       <= pipe_d;
            overrun_q    <= overrun_d;
            sram_addr_q  <= sram_addr_d;
            sram_re_q    <= sram_re_d;
            sram_we_q    <= sram_we_d;
            sram_wdata_q <= sram_wdata_d;
            mem_out_q    <= mem_out_d;
            mem_valid_q  <= mem_valid_d;
        end
    end

    assign mem_out      = mem_out_q;
    assign mem_valid    = mem_valid_q;
    assign mem_burstlen = 16'(BURSTLEN);
    assign req_overrun  = overrun_q;
    assign sram_addr    = sram_addr_q;
    assign sram_re      = sram_re_q;
    assign sram_we      = sram_we_q;
    assign sram_wdata   = sram_wdata_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: SRAM model, queue-based reference model checked every cycle, directed scenarios.
// Honours DCACHE_MEMRESP_WRAP_EN for the expected burst address order.
module tb_dcache_mem_responder;

    localparam int BURSTLEN = 8;
    localparam int RDLAT    = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic        mem_rdreq;
    logic        mem_wrreq;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_out;
    logic        mem_valid;
    logic [15:0] mem_burstlen;
    logic        req_overrun;
    logic [29:0] sram_addr;
    logic        sram_re;
    logic        sram_we;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checkCount = 0;
    int failCount  = 0;

    dcache_mem_responder #(.BURSTLEN(BURSTLEN), .RDLAT(RDLAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_addr     (mem_addr),
        .mem_rdreq    (mem_rdreq),
        .mem_wrreq    (mem_wrreq),
        .mem_wrdata   (mem_wrdata),
        .mem_out      (mem_out),
        .mem_valid    (mem_valid),
        .mem_burstlen (mem_burstlen),
        .req_overrun  (req_overrun),
        .sram_addr    (sram_addr),
        .sram_re      (sram_re),
        .sram_we      (sram_we),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // SRAM backend: word array aliased on the low 12 address bits, read data appears RDLAT cycles after sram_re.
    logic [31:0] sramMem [0:4095];
    logic [31:0] rdPipe  [0:RDLAT-1];
    assign sram_rdata = rdPipe[RDLAT-1];

    initial begin
        for (int i = 0; i < 4096; i++) sramMem[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < RDLAT; i++) rdPipe[i] = 32'h0;
        forever begin
            @(posedge clk);
            if (sram_we) sramMem[sram_addr[11:0]] <= sram_wdata;
            rdPipe[0] <= sram_re ? sramMem[sram_addr[11:0]] : 32'h0;
            for (int i = 1; i < RDLAT; i++) rdPipe[i] <= rdPipe[i-1];
        end
    end

    // Reference model: pending word addresses and scheduled beats, stepped on every rising edge.
    typedef struct {
        int          due;
        logic [31:0] data;
    } beat_t;

    logic [31:0] refMem [0:4095];
    logic [29:0] issueQ [$];
    beat_t       beatQ  [$];
    int          remaining = 0;
    int          edgeNo    = 0;
    logic        modelBusy;
    logic        modelOverrun = 1'b0;
    logic [29:0] mBase;
    logic [29:0] mAddr;
    logic        expRe = 1'b0, expWe = 1'b0, expValid = 1'b0;
    logic [29:0] expAddr = '0;
    logic [31:0] expWdata = '0, expOut = '0;

    initial begin
        for (int i = 0; i < 4096; i++) refMem[i] = 32'hA000_0000 + 32'(i);
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                issueQ.delete();
                beatQ.delete();
                remaining    = 0;
                modelOverrun = 1'b0;
                expRe        = 1'b0;
                expWe        = 1'b0;
                expValid     = 1'b0;
            end else begin
                edgeNo++;
                modelBusy = (remaining != 0);
                expRe     = 1'b0;
                expWe     = 1'b0;
                expValid  = 1'b0;
                if (beatQ.size() != 0 && beatQ[0].due == edgeNo) begin
                    expValid = 1'b1;
                    expOut   = beatQ[0].data;
                    void'(beatQ.pop_front());
                    remaining--;
                end
                if (mem_wrreq) begin
                    expWe    = 1'b1;
                    expAddr  = mem_addr[31:2];
                    expWdata = mem_wrdata;
                    refMem[mem_addr[13:2]] = mem_wrdata;
                end else if (issueQ.size() != 0) begin
                    mAddr   = issueQ.pop_front();
                    expRe   = 1'b1;
                    expAddr = mAddr;
                    beatQ.push_back('{due: edgeNo + RDLAT + 1, data: refMem[mAddr[11:0]]});
                end
                if (mem_rdreq) begin
                    if (modelBusy) begin
                        modelOverrun = 1'b1;
                    end else begin
                        mBase     = mem_addr[31:2];
                        remaining = BURSTLEN;
                        for (int i = 0; i < BURSTLEN; i++) begin
`ifdef DCACHE_MEMRESP_WRAP_EN
                            issueQ.push_back({mBase[29:5], 5'(mBase[4:0] + 5'(i))});
`else
                            issueQ.push_back(30'(mBase + 30'(i)));
`endif
                        end
                    end
                end
            end
        end
    end

    // Observation log used by the scenario checks.
    int          cycNo = 0;
    logic [31:0] seenBeats  [$];
    int          beatCyc    [$];
    logic [29:0] seenRdAddr [$];
    int          rdCyc      [$];
    int          weCyc      [$];

    initial begin
        forever begin
            @(negedge clk);
            cycNo++;
            if (!reset_n) begin
                checkOutput("reset mem_valid", 32'(mem_valid), 32'h0);
                checkOutput("reset mem_out", mem_out, 32'h0);
                checkOutput("reset req_overrun", 32'(req_overrun), 32'h0);
                checkOutput("reset sram_re", 32'(sram_re), 32'h0);
                checkOutput("reset sram_we", 32'(sram_we), 32'h0);
                checkOutput("reset sram_addr", 32'(sram_addr), 32'h0);
                checkOutput("reset sram_wdata", sram_wdata, 32'h0);
            end else begin
                checkOutput("mem_valid", 32'(mem_valid), 32'(expValid));
                if (expValid) checkOutput("mem_out", mem_out, expOut);
                checkOutput("sram_re", 32'(sram_re), 32'(expRe));
                checkOutput("sram_we", 32'(sram_we), 32'(expWe));
                if (expRe || expWe) checkOutput("sram_addr", 32'(sram_addr), 32'(expAddr));
                if (expWe) checkOutput("sram_wdata", sram_wdata, expWdata);
                checkOutput("req_overrun", 32'(req_overrun), 32'(modelOverrun));
                if (mem_valid) begin
                    seenBeats.push_back(mem_out);
                    beatCyc.push_back(cycNo);
                end
                if (sram_re) begin
                    seenRdAddr.push_back(sram_addr);
                    rdCyc.push_back(cycNo);
                end
                if (sram_we) weCyc.push_back(cycNo);
            end
            checkOutput("mem_burstlen", 32'(mem_burstlen), 32'(BURSTLEN));
        end
    end

    function automatic logic [31:0] beatAt(input int i);
        return (i < seenBeats.size()) ? seenBeats[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rdAddrAt(input int i);
        return (i < seenRdAddr.size()) ? 32'(seenRdAddr[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic int beatCycAt(input int i);
        return (i < beatCyc.size()) ? beatCyc[i] : -1000;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        mem_rdreq  = rd;
        mem_wrreq  = wr;
        mem_addr   = addr;
        mem_wrdata = wdata;
        @(posedge clk);
        #1;
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
    endtask

    task automatic clearSeen();
        seenBeats.delete();
        beatCyc.delete();
        seenRdAddr.delete();
        rdCyc.delete();
        weCyc.delete();
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while ((remaining != 0 || issueQ.size() != 0) && n < 300) begin
            idle(1);
            n++;
        end
        checkOutput({name, " finished in time"}, 32'(n < 300), 32'h1);
        idle(2);
    endtask

    task automatic checkBurst(input string name, input logic [31:0] firstWord);
        checkOutput({name, " beat count"}, 32'(seenBeats.size()), 32'(BURSTLEN));
        for (int i = 0; i < BURSTLEN; i++)
            checkOutput($sformatf("%s beat %0d", name, i), beatAt(i), firstWord + 32'(i));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          n;
        int          saved;
        logic [29:0] expOrder [0:7];

        mem_addr   = '0;
        mem_rdreq  = 1'b0;
        mem_wrreq  = 1'b0;
        mem_wrdata = '0;
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        $display("[TB] linear burst");
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        waitDone("linear");
        checkBurst("linear", 32'hA000_0040);
        checkOutput("linear first sram_addr", rdAddrAt(0), 32'h40);
        checkOutput("linear re-to-valid latency", 32'(beatCycAt(0) - (rdCyc.size() > 0 ? rdCyc[0] : 0)), 32'd3);
        checkOutput("linear contiguous beats", 32'(beatCycAt(7) - beatCycAt(0)), 32'd7);

        $display("[TB] write collision");
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF);
        waitDone("collision");
        checkBurst("collision", 32'hA000_0040);
        checkOutput("collision write strobes", 32'(weCyc.size()), 32'd1);
        checkOutput("collision beat span with gap", 32'(beatCycAt(7) - beatCycAt(0)), 32'd8);
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        waitDone("readback");
        checkOutput("readback word 0x100", beatAt(0), 32'hDEAD_BEEF);
        checkOutput("readback word 0x101", beatAt(1), 32'hA000_0101);

        $display("[TB] flush pattern");
        clearSeen();
        for (int k = 0; k < 32; k++)
            applyStimulus(1'b0, 1'b1, 32'h0000_1000 + 32'(4 * k), 32'(k));
        idle(3);
        checkOutput("flush write strobes", 32'(weCyc.size()), 32'd32);
        checkOutput("flush no beats", 32'(seenBeats.size()), 32'd0);
        checkOutput("flush sram 0x400", sramMem[12'h400], 32'd0);
        checkOutput("flush sram 0x411", sramMem[12'h411], 32'd17);
        checkOutput("flush sram 0x41F", sramMem[12'h41F], 32'd31);
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        waitDone("flush read");
        checkBurst("flush read", 32'h0);

        $display("[TB] read and write together in idle");
        clearSeen();
        applyStimulus(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678);
        waitDone("rdwr");
        checkOutput("rdwr first beat", beatAt(0), 32'h1234_5678);
        checkOutput("rdwr second beat", beatAt(1), 32'hA000_0801);
        checkOutput("rdwr read follows write", 32'((rdCyc.size() > 0 ? rdCyc[0] : 0) - (weCyc.size() > 0 ? weCyc[0] : 0)), 32'd1);

        $display("[TB] overrun");
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        idle(8);
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        waitDone("overrun");
        idle(10);
        checkBurst("overrun", 32'hA000_0040);
        checkOutput("overrun flag set", 32'(req_overrun), 32'h1);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        checkOutput("overrun flag cleared by reset", 32'(req_overrun), 32'h0);

        $display("[TB] back-to-back bursts");
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        n = 0;
        while (remaining != 0 && n < 100) begin
            idle(1);
            n++;
        end
        checkOutput("b2b first burst drained", 32'(n < 100), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        waitDone("b2b");
        checkOutput("b2b total beats", 32'(seenBeats.size()), 32'd16);
        checkOutput("b2b second burst first word", beatAt(8), 32'hA000_0080);
        checkOutput("b2b no overrun", 32'(req_overrun), 32'h0);

        $display("[TB] line boundary order");
`ifdef DCACHE_MEMRESP_WRAP_EN
        expOrder = '{30'h1E, 30'h1F, 30'h00, 30'h01, 30'h02, 30'h03, 30'h04, 30'h05};
`else
        expOrder = '{30'h1E, 30'h1F, 30'h20, 30'h21, 30'h22, 30'h23, 30'h24, 30'h25};
`endif
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_0078, 32'h0);
        waitDone("boundary");
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("boundary sram_addr %0d", i), rdAddrAt(i), 32'(expOrder[i]));
        checkOutput("boundary third beat", beatAt(2), 32'hA000_0000 + 32'(expOrder[2]));

        $display("[TB] top of address space");
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
        waitDone("top");
        checkOutput("top sram_addr 1", rdAddrAt(1), 32'h3FFF_FFFF);
`ifdef DCACHE_MEMRESP_WRAP_EN
        checkOutput("top sram_addr 2", rdAddrAt(2), 32'h3FFF_FFE0);
`else
        checkOutput("top sram_addr 2", rdAddrAt(2), 32'h0000_0000);
`endif

        $display("[TB] reset mid-burst");
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        n = 0;
        while (seenBeats.size() < 3 && n < 100) begin
            idle(1);
            n++;
        end
        checkOutput("midreset reached three beats", 32'(n < 100), 32'h1);
        saved   = seenBeats.size();
        reset_n = 1'b0;
        #1;
        checkOutput("midreset mem_valid at reset", 32'(mem_valid), 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(15);
        checkOutput("midreset no beats after reset", 32'(seenBeats.size()), 32'(saved));
        clearSeen();
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        waitDone("after reset");
        checkBurst("after reset", 32'hA000_0040);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
